// File: rtl/seq_pkg.sv
// Shared definitions for the cycle sequencer and the instruction decoder:
// state encoding, interrupt source codes and default configuration values.
package seq_pkg;

    typedef enum logic [1:0] {
        S_RST   = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10
    } seq_state_e;

    typedef enum logic [1:0] {
        INT_NONE = 2'b00,
        INT_IRQ  = 2'b01,
        INT_NMI  = 2'b10,
        INT_RST  = 2'b11
    } int_src_e;

    localparam int         RST_CYCLES_DEF = 2;
    localparam int         MAX_CYCLE_DEF  = 7;
    localparam logic [7:0] INT_OPCODE_DEF = 8'h00;

    // Widened add so an overflow past the last cycle index stays visible.
    function automatic logic [3:0] next_cycle(input logic [2:0] cur, input logic skip);
        return {1'b0, cur} + (skip ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// Registers nmi_n and flags a falling edge for one cycle.
module nmi_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic nmi_n,
    output logic fall
);

    logic nmi_q;
    logic nmi_d;

    always_comb begin
        nmi_d = nmi_n;
    end

    // Idle level is high so a line already low at reset does not look like an edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            nmi_q <= 1'b1;
        end else begin
            nmi_q <= nmi_d;
        end
    end

    assign fall = nmi_q & ~nmi_n;

endmodule

// File: rtl/cycle_sequencer.sv
// Latches opcodes, steps the decoder cycle count and injects reset/IRQ/NMI
// service sequences. Edge-triggered NMI support is enabled by SEQ_NMI_EN.
module cycle_sequencer
    import seq_pkg::*;
#(
    parameter int         RST_CYCLES = RST_CYCLES_DEF,
    parameter int         MAX_CYCLE  = MAX_CYCLE_DEF,
    parameter logic [7:0] INT_OPCODE = INT_OPCODE_DEF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rdy,
    input  logic [7:0] data_in,
    input  logic       icyc,
    input  logic       scyc,
    input  logic       rcyc,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       i_flag,
    output logic [7:0] inst,
    output logic [2:0] cycle,
    output logic       dec_clr,
    output logic       sync,
    output logic [1:0] int_src,
    output logic       err
);

    localparam logic [2:0] RST_LAST  = 3'(RST_CYCLES - 1);
    localparam logic [3:0] MAX_CYC4  = 4'(MAX_CYCLE);

    seq_state_e state_q, state_d;
    int_src_e   int_src_q, int_src_d;
    logic [7:0] inst_q, inst_d;
    logic [2:0] cycle_q, cycle_d;
    logic [2:0] rst_cnt_q, rst_cnt_d;
    logic       err_q, err_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_fall;
    logic       nmi_take;
    logic [3:0] cyc_next;

`ifdef SEQ_NMI_EN
    nmi_edge_det u_nmi_edge_det (
        .clk   (clk),
        .clr   (clr),
        .nmi_n (nmi_n),
        .fall  (nmi_fall)
    );
`else
    logic nmi_n_unused;
    assign nmi_n_unused = nmi_n;
    assign nmi_fall     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        int_src_d = int_src_q;
        inst_d    = inst_q;
        cycle_d   = cycle_q;
        rst_cnt_d = rst_cnt_q;
        err_d     = 1'b0;
        nmi_take  = 1'b0;
        cyc_next  = next_cycle(cycle_q, scyc);

        if (rdy) begin
            case (state_q)
                S_RST: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_d   = S_EXEC;
                        cycle_d   = 3'd1;
                        inst_d    = INT_OPCODE;
                        int_src_d = INT_RST;
                        rst_cnt_d = 3'd0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 3'd1;
                    end
                end
                S_FETCH: begin
                    state_d = S_EXEC;
                    cycle_d = 3'd1;
                    if (nmi_pend_q) begin
                        nmi_take  = 1'b1;
                        inst_d    = INT_OPCODE;
                        int_src_d = INT_NMI;
                    end else if (!irq_n && !i_flag) begin
                        inst_d    = INT_OPCODE;
                        int_src_d = INT_IRQ;
                    end else begin
                        inst_d    = data_in;
                        int_src_d = INT_NONE;
                    end
                end
                S_EXEC: begin
                    if (rcyc) begin
                        state_d = S_FETCH;
                        cycle_d = 3'd0;
                    end else if (scyc || icyc) begin
                        // Stepping past the last legal cycle aborts back to fetch.
                        if (cyc_next > MAX_CYC4) begin
                            state_d = S_FETCH;
                            cycle_d = 3'd0;
                            err_d   = 1'b1;
                        end else begin
                            cycle_d = cyc_next[2:0];
                        end
                    end
                end
                default: begin
                    state_d = S_RST;
                    cycle_d = 3'd0;
                end
            endcase
        end

        // A fresh edge in the same cycle as the take keeps the request pending.
        nmi_pend_d = (nmi_pend_q & ~nmi_take) | nmi_fall;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_RST;
            int_src_q  <= INT_RST;
            inst_q     <= INT_OPCODE;
            cycle_q    <= 3'd0;
            rst_cnt_q  <= 3'd0;
            err_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_src_q  <= int_src_d;
            inst_q     <= inst_d;
            cycle_q    <= cycle_d;
            rst_cnt_q  <= rst_cnt_d;
            err_q      <= err_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    assign inst    = inst_q;
    assign cycle   = cycle_q;
    assign int_src = int_src_q;
    assign err     = err_q;
    assign sync    = (state_q == S_FETCH);
    assign dec_clr = (state_q == S_RST);

endmodule
